// File: rtl/tokenizer_pkg.sv
// Shared types and constants for the word tokenizer: token encodings,
// match-FSM states, FIFO geometry and character helpers.
package tokenizer_pkg;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;
    localparam int unsigned LEN_W      = 4;
    localparam int unsigned TYPE_W     = 2;

    localparam logic [7:0]        SPACE_CHAR = 8'h20;
    localparam logic [LEN_W-1:0]  LEN_MAX    = '1;

    localparam logic [TYPE_W-1:0] TOK_BEGIN = 2'b01;
    localparam logic [TYPE_W-1:0] TOK_END   = 2'b10;
    localparam logic [TYPE_W-1:0] TOK_OTHER = 2'b11;

    typedef enum logic [3:0] {
        ST_SPACE,
        ST_B,
        ST_BE,
        ST_BEG,
        ST_BEGI,
        ST_BEGIN,
        ST_E,
        ST_EN,
        ST_END,
        ST_OTHER
    } state_t;

    typedef struct packed {
        logic [TYPE_W-1:0] kind;
        logic [LEN_W-1:0]  len;
    } token_t;

    function automatic logic [7:0] fold_case(input logic [7:0] c);
        return ((c >= 8'h41) && (c <= 8'h5A)) ? (c | 8'h20) : c;
    endfunction

    // Advance the keyword matcher on one non-space, already case-folded byte.
    function automatic state_t match_step(input state_t st, input logic [7:0] c);
        state_t nxt;
        nxt = ST_OTHER;
        case (st)
            ST_SPACE: nxt = (c == "b") ? ST_B : ((c == "e") ? ST_E : ST_OTHER);
            ST_B:     nxt = (c == "e") ? ST_BE    : ST_OTHER;
            ST_BE:    nxt = (c == "g") ? ST_BEG   : ST_OTHER;
            ST_BEG:   nxt = (c == "i") ? ST_BEGI  : ST_OTHER;
            ST_BEGI:  nxt = (c == "n") ? ST_BEGIN : ST_OTHER;
            ST_E:     nxt = (c == "n") ? ST_EN    : ST_OTHER;
            ST_EN:    nxt = (c == "d") ? ST_END   : ST_OTHER;
            default:  nxt = ST_OTHER;
        endcase
        return nxt;
    endfunction

    function automatic logic [TYPE_W-1:0] token_kind(input state_t st);
        case (st)
            ST_BEGIN: return TOK_BEGIN;
            ST_END:   return TOK_END;
            default:  return TOK_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/token_fifo.sv
// Four-entry token queue with registered occupancy and full/empty flags;
// the head entry reads as zero while the queue is empty.
module token_fifo
    import tokenizer_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  token_t push_data,
    input  logic   pop,
    output token_t head_c,
    output logic   full,
    output logic   empty
);

    token_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_d;
    logic               do_push;
    logic               do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head_c  = empty ? '0 : mem[rd_ptr];

    always_comb begin
        count_d = count;
        if (do_push && !do_pop) begin
            count_d = count + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count - CNT_W'(1);
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_d;
            full  <= (count_d == CNT_W'(FIFO_DEPTH));
            empty <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/word_tokenizer.sv
// Splits a character stream into space-delimited words and classifies each
// word as BEGIN, END or OTHER, queuing {type, length} tokens.
module word_tokenizer
    import tokenizer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_char,
    input  logic              in_last,
    output logic              in_ready,
    output logic              tok_valid,
    output logic [TYPE_W-1:0] tok_type,
    output logic [LEN_W-1:0]  tok_len,
    input  logic              tok_ready
);

    state_t             state_q;
    state_t             state_d;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_d;
    logic [7:0]         ch;
    logic               accept;
    logic               push;
    token_t             push_tok;
    token_t             head;
    logic               fifo_full;
    logic               fifo_empty;

    assign accept    = in_valid & in_ready;
    assign in_ready  = ~fifo_full;
    assign tok_valid = ~fifo_empty;
    assign tok_type  = head.kind;
    assign tok_len   = head.len;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SPACE;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    // A delimiter closes the current word; in_last closes it after the byte is absorbed.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        push          = 1'b0;
        push_tok      = '0;
        ch            = fold_case(in_char);
        if (accept) begin
            if (ch == SPACE_CHAR) begin
                if (len_q != '0) begin
                    push          = 1'b1;
                    push_tok.kind = token_kind(state_q);
                    push_tok.len  = len_q;
                end
                state_d = ST_SPACE;
                len_d   = '0;
            end else begin
                state_d = match_step(state_q, ch);
                len_d   = (len_q == LEN_MAX) ? len_q : len_q + LEN_W'(1);
            end
            if (in_last) begin
                if (len_d != '0) begin
                    push          = 1'b1;
                    push_tok.kind = token_kind(state_d);
                    push_tok.len  = len_d;
                end
                state_d = ST_SPACE;
                len_d   = '0;
            end
        end
    end

    token_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_tok),
        .pop       (tok_ready),
        .head_c    (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
